// File: rtl/mac_unit.sv
// Signed multiply-accumulate: operands are registered, multiplied at full
// precision and added into a registered accumulator that drives f.
module mac_unit #(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [ACC_W-1:0] f
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [IN_W-1:0]   a_r;
  logic signed [IN_W-1:0]   b_r;
  logic signed [2*IN_W-1:0] prod_s;
  logic signed [ACC_W:0]    sum_s;
  logic signed [ACC_W-1:0]  next_f_s;

  // An extended sum whose two top bits differ has left the ACC_W range.
  function automatic logic signed [ACC_W-1:0] clamp_fn(input logic signed [ACC_W:0] s);
    logic signed [ACC_W-1:0] r;
    if (s[ACC_W] == s[ACC_W-1]) begin
      r = s[ACC_W-1:0];
    end else if (s[ACC_W] == 1'b0) begin
      r = ACC_MAX;
    end else begin
      r = ACC_MIN;
    end
    return r;
  endfunction

  // Full-precision product and one-bit-wider sum, then clamp or wrap.
  always_comb begin
    prod_s = a_r * b_r;
    sum_s  = (ACC_W+1)'(f) + (ACC_W+1)'(prod_s);
    if (SATURATE) begin
      next_f_s = clamp_fn(sum_s);
    end else begin
      next_f_s = sum_s[ACC_W-1:0];
    end
  end

  // Operand and accumulator registers; reset discards the in-flight pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= {IN_W{1'b0}};
      b_r <= {IN_W{1'b0}};
      f   <= {ACC_W{1'b0}};
    end else begin
      a_r <= a;
      b_r <= b;
      f   <= next_f_s;
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed scenarios plus randomized
// streams checked against an integer reference model.
module tb_mac_unit;

  localparam int IN_W  = 8;
  localparam int ACC_W = 16;
  localparam int MAXV  = (2 ** (ACC_W - 1)) - 1;
  localparam int MINV  = -(2 ** (ACC_W - 1));

  logic                    clk;
  logic                    reset;
  logic signed [IN_W-1:0]  a;
  logic signed [IN_W-1:0]  b;
  logic signed [ACC_W-1:0] f;

  int pass_cnt;
  int total_cnt;

  // Reference model: running sum plus the product of the pair waiting to be added.
  int exp_f;
  int pend;

  mac_unit #(.IN_W(IN_W), .ACC_W(ACC_W), .SATURATE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .f     (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Apply one operand pair for one rising edge, advance the model, settle.
  task automatic step(input int av, input int bv, input bit rst);
    a     = IN_W'(av);
    b     = IN_W'(bv);
    reset = rst;
    @(posedge clk);
    if (rst) begin
      exp_f = 0;
      pend  = 0;
    end else begin
      exp_f = clamp(exp_f + pend);
      pend  = av * bv;
    end
    #1;
  endtask

  task automatic run_seq(input string name, input int av[], input int bv[], input int fv[]);
    for (int i = 0; i < av.size(); i++) begin
      step(av[i], bv[i], 1'b0);
      total_cnt++;
      if (int'(f) !== fv[i]) begin
        $display("FAIL %s step %0d: f=%0d expected %0d", name, i, int'(f), fv[i]);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    step(5, 7, 1'b1);
    total_cnt++;
    if (int'(f) !== 0) $display("FAIL reset_clear: f=%0d expected 0", int'(f));
    else pass_cnt++;
    step(0, 0, 1'b0);
    total_cnt++;
    if (int'(f) !== 0) $display("FAIL reset_idle: f=%0d expected 0", int'(f));
    else pass_cnt++;
  endtask

  task automatic test_basic();
    step(0, 0, 1'b1);
    run_seq("basic", '{3, -2, 10, 0, 0}, '{4, 5, -10, 0, 0}, '{0, 12, 2, -98, -98});
  endtask

  task automatic test_corner_product();
    step(0, 0, 1'b1);
    run_seq("corner", '{-128, 0, -128, 0}, '{-128, 0, 127, 0}, '{0, 16384, 16384, 128});
  endtask

  task automatic test_pos_sat();
    step(0, 0, 1'b1);
    run_seq("pos_sat", '{-128, -128, -128, -1, 0}, '{-128, -128, -128, 1, 0},
            '{0, 16384, 32767, 32767, 32766});
  endtask

  task automatic test_neg_sat();
    step(0, 0, 1'b1);
    run_seq("neg_sat", '{-128, -128, -128, 1, 0}, '{127, 127, 127, 1, 0},
            '{0, -16256, -32512, -32768, -32767});
  endtask

  task automatic test_mid_reset();
    step(0, 0, 1'b1);
    run_seq("mid_pre", '{3, 0}, '{4, 0}, '{0, 12});
    step(9, 9, 1'b1);
    total_cnt++;
    if (int'(f) !== 0) $display("FAIL mid_reset_clear: f=%0d expected 0", int'(f));
    else pass_cnt++;
    run_seq("mid_post", '{2, 0, 0}, '{3, 0, 0}, '{0, 6, 6});
  endtask

  task automatic test_random();
    int av, bv;
    bit rst;
    step(0, 0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (i % 100 < 50) begin
        av = int'($urandom_range(0, 255)) - 128;
        bv = int'($urandom_range(0, 255)) - 128;
      end else begin
        av = int'($urandom_range(0, 15)) - 8;
        bv = int'($urandom_range(0, 15)) - 8;
      end
      rst = ($urandom_range(0, 49) == 0);
      step(av, bv, rst);
      total_cnt++;
      if (int'(f) !== exp_f) begin
        $display("FAIL random step %0d: f=%0d expected %0d", i, int'(f), exp_f);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_f     = 0;
    pend      = 0;
    a         = '0;
    b         = '0;
    reset     = 1'b1;
    test_reset();
    test_basic();
    test_corner_product();
    test_pos_sat();
    test_neg_sat();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
